// File: rtl/control_unit.sv
// Microcoded sequencer for the 8-bit bus datapath: fetches into IR, walks per-opcode
// micro-steps and decodes every datapath control line from the registered state.
module control_unit #(
    parameter logic [2:0] RESET_STEP = 3'd0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_bus,
    input  logic       i_aluFlagN,
    input  logic       i_aluFlagZ,
    input  logic       i_run,
    output logic       o_ctrlAluOE,
    output logic       o_ctrlAluSubShiftDir,
    output logic       o_ctrlAluBWr,
    output logic [1:0] o_ctrlAluOp,
    output logic       o_ctrlRegWr0,
    output logic       o_ctrlRegWr1,
    output logic       o_ctrlRegBusSel,
    output logic       o_ctrlRegBusEn,
    output logic       o_ctrlAluSel,
    output logic       o_ctrlRamAddressEn,
    output logic       o_ctrlRamWriteEn,
    output logic       o_ctrlRamReadDataSelect,
    output logic       o_ctrlRamOE,
    output logic       o_ctrlLoadPC,
    output logic       o_ctrlIncrPC,
    output logic       o_ctrlPCOe,
    output logic       o_halted,
    output logic [7:0] o_ir
);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_AND = 4'h4, OP_OR  = 4'h5, OP_LD  = 4'h6, OP_ST  = 4'h7,
        OP_JMP = 4'h8, OP_JZ  = 4'h9, OP_JN  = 4'hA, OP_SHL = 4'hB,
        OP_SHR = 4'hC, OP_HLT = 4'hF
    } opcode_t;

    logic [7:0] ir;
    logic [2:0] step;
    logic       flag_n;
    logic       flag_z;
    logic       halted;

    opcode_t    opcode;
    logic       r;
    logic       is_alu;
    logic       taken;
    logic [1:0] alu_op;
    logic       alu_dir;
    logic [2:0] last_step;
    logic       active;

    assign opcode   = opcode_t'(ir[7:4]);
    assign r        = ir[0];
    assign active   = !i_reset && i_run && !halted;
    assign o_halted = halted;
    assign o_ir     = ir;

    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        is_alu  = 1'b0;
        alu_op  = 2'b00;
        alu_dir = 1'b0;
        case (opcode)
            OP_ADD:  is_alu = 1'b1;
            OP_SUB:  begin is_alu = 1'b1; alu_dir = 1'b1; end
            OP_AND:  begin is_alu = 1'b1; alu_op = 2'b01; end
            OP_OR:   begin is_alu = 1'b1; alu_op = 2'b10; end
            OP_SHL:  begin is_alu = 1'b1; alu_op = 2'b11; end
            OP_SHR:  begin is_alu = 1'b1; alu_op = 2'b11; alu_dir = 1'b1; end
            default: ;
        endcase

        taken = (opcode == OP_JMP) || (opcode == OP_JZ && flag_z) || (opcode == OP_JN && flag_n);

        case (opcode)
            OP_LDI, OP_JMP: last_step = 3'd3;
            OP_LD, OP_ST:   last_step = 3'd4;
            OP_JZ, OP_JN:   last_step = taken ? 3'd3 : 3'd2;
            default:        last_step = is_alu ? 3'd3 : 3'd2;
        endcase
    end

    always_comb begin
        o_ctrlAluOE             = 1'b0;
        o_ctrlAluSubShiftDir    = 1'b0;
        o_ctrlAluBWr            = 1'b0;
        o_ctrlAluOp             = 2'b00;
        o_ctrlRegWr0            = 1'b0;
        o_ctrlRegWr1            = 1'b0;
        o_ctrlRegBusSel         = 1'b0;
        o_ctrlRegBusEn          = 1'b0;
        o_ctrlAluSel            = 1'b0;
        o_ctrlRamAddressEn      = 1'b0;
        o_ctrlRamWriteEn        = 1'b0;
        o_ctrlRamReadDataSelect = 1'b0;
        o_ctrlRamOE             = 1'b0;
        o_ctrlLoadPC            = 1'b0;
        o_ctrlIncrPC            = 1'b0;
        o_ctrlPCOe              = 1'b0;
        if (active) begin
            case (step)
                3'd0: begin o_ctrlPCOe = 1'b1; o_ctrlRamAddressEn = 1'b1; end
                3'd1: begin o_ctrlRamOE = 1'b1; o_ctrlIncrPC = 1'b1; end
                3'd2: begin
                    if (is_alu) begin
                        o_ctrlRegBusEn       = 1'b1;
                        o_ctrlRegBusSel      = ~r;
                        o_ctrlAluSel         = r;
                        o_ctrlAluBWr         = 1'b1;
                        o_ctrlAluOp          = alu_op;
                        o_ctrlAluSubShiftDir = alu_dir;
                    end else begin
                        case (opcode)
                            OP_LDI, OP_LD, OP_ST: begin
                                o_ctrlPCOe = 1'b1; o_ctrlRamAddressEn = 1'b1;
                            end
                            // An untaken branch only steps the PC over its operand byte.
                            OP_JMP, OP_JZ, OP_JN: begin
                                o_ctrlPCOe         = taken;
                                o_ctrlRamAddressEn = taken;
                                o_ctrlIncrPC       = !taken;
                            end
                            default: ;
                        endcase
                    end
                end
                3'd3: begin
                    if (is_alu) begin
                        o_ctrlAluOE          = 1'b1;
                        o_ctrlAluSel         = r;
                        o_ctrlRegBusSel      = ~r;
                        o_ctrlAluOp          = alu_op;
                        o_ctrlAluSubShiftDir = alu_dir;
                        o_ctrlRegWr0         = ~r;
                        o_ctrlRegWr1         = r;
                    end else begin
                        case (opcode)
                            OP_LDI: begin
                                o_ctrlRamOE = 1'b1; o_ctrlIncrPC = 1'b1;
                                o_ctrlRegWr0 = ~r; o_ctrlRegWr1 = r;
                            end
                            OP_LD, OP_ST: begin
                                o_ctrlRamOE = 1'b1; o_ctrlRamAddressEn = 1'b1; o_ctrlIncrPC = 1'b1;
                            end
                            OP_JMP, OP_JZ, OP_JN: begin
                                o_ctrlRamOE = 1'b1; o_ctrlLoadPC = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                3'd4: begin
                    if (opcode == OP_LD) begin
                        o_ctrlRamOE = 1'b1; o_ctrlRegWr0 = ~r; o_ctrlRegWr1 = r;
                    end else if (opcode == OP_ST) begin
                        o_ctrlRegBusEn = 1'b1; o_ctrlRegBusSel = r; o_ctrlRamWriteEn = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ir     <= 8'h00;
            step   <= RESET_STEP;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            halted <= 1'b0;
        end else if (i_run && !halted) begin
            if (step > 3'd4) begin
                step <= 3'd0;
            end else if (step == 3'd0) begin
                step <= 3'd1;
            end else if (step == 3'd1) begin
                ir   <= i_bus;
                step <= 3'd2;
            end else begin
                if (is_alu && step == 3'd3) begin
                    flag_n <= i_aluFlagN;
                    flag_z <= i_aluFlagZ;
                end
                if (step >= last_step) begin
                    step <= 3'd0;
                    if (opcode == OP_HLT) halted <= 1'b1;
                end else begin
                    step <= step + 3'd1;
                end
            end
        end
    end

    bus_exclusive: assert property (@(posedge i_clk)
        $onehot0({o_ctrlAluOE, o_ctrlRegBusEn, o_ctrlRamOE, o_ctrlPCOe}));

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small datapath model (PC, MAR, two registers, ALU, RAM)
// closes the loop while a scoreboard of expected per-cycle control words is checked.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       i_reset, i_run, i_aluFlagN, i_aluFlagZ;
    logic [7:0] bus;
    logic       alu_oe, sub, bwr, wr0, wr1, bus_sel, bus_en, alu_sel;
    logic       ram_ae, ram_we, ram_rds, ram_oe, load_pc, incr_pc, pc_oe, halted;
    logic [1:0] op;
    logic [7:0] ir;
    logic [16:0] ctrl;

    always #5 clk = ~clk;

    control_unit #(.RESET_STEP(3'd0)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_bus(bus),
        .i_aluFlagN(i_aluFlagN), .i_aluFlagZ(i_aluFlagZ), .i_run(i_run),
        .o_ctrlAluOE(alu_oe), .o_ctrlAluSubShiftDir(sub), .o_ctrlAluBWr(bwr),
        .o_ctrlAluOp(op), .o_ctrlRegWr0(wr0), .o_ctrlRegWr1(wr1),
        .o_ctrlRegBusSel(bus_sel), .o_ctrlRegBusEn(bus_en), .o_ctrlAluSel(alu_sel),
        .o_ctrlRamAddressEn(ram_ae), .o_ctrlRamWriteEn(ram_we),
        .o_ctrlRamReadDataSelect(ram_rds), .o_ctrlRamOE(ram_oe),
        .o_ctrlLoadPC(load_pc), .o_ctrlIncrPC(incr_pc), .o_ctrlPCOe(pc_oe),
        .o_halted(halted), .o_ir(ir)
    );

    assign ctrl = {alu_oe, sub, bwr, op[1], op[0], wr0, wr1, bus_sel, bus_en, alu_sel,
                   ram_ae, ram_we, ram_rds, ram_oe, load_pc, incr_pc, pc_oe};

    localparam logic [16:0] PC_OE  = 17'h00001, INC    = 17'h00002, LDPC   = 17'h00004;
    localparam logic [16:0] RAM_OE = 17'h00008, RAM_WE = 17'h00020, RAM_AE = 17'h00040;
    localparam logic [16:0] ALU_SEL = 17'h00080, BUS_EN = 17'h00100, BUS_SEL = 17'h00200;
    localparam logic [16:0] WR1 = 17'h00400, WR0 = 17'h00800, OP0 = 17'h01000, OP1 = 17'h02000;
    localparam logic [16:0] BWR = 17'h04000, SUB = 17'h08000, ALU_OE = 17'h10000;
    localparam logic [16:0] F0 = PC_OE | RAM_AE, F1 = RAM_OE | INC, IMM = PC_OE | RAM_AE;

    // Datapath model
    logic [7:0] rom   [256];
    logic [7:0] wmem  [256];
    logic       wvalid[256];
    logic [7:0] regs  [2];
    logic [7:0] pc, mar, breg, pc_start, alu_a, alu_res;
    logic       mem_clr;
    int         we_count;

    always_comb begin
        alu_a = regs[alu_sel];
        case (op)
            2'b00:   alu_res = sub ? alu_a - breg : alu_a + breg;
            2'b01:   alu_res = alu_a & breg;
            2'b10:   alu_res = alu_a | breg;
            default: alu_res = sub ? alu_a >> 1 : alu_a << 1;
        endcase
        i_aluFlagN = alu_res[7];
        i_aluFlagZ = (alu_res == 8'h00);
        if (pc_oe)       bus = pc;
        else if (ram_oe) bus = wvalid[mar] ? wmem[mar] : rom[mar];
        else if (bus_en) bus = regs[bus_sel];
        else if (alu_oe) bus = alu_res;
        else             bus = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) wvalid[i] <= 1'b0;
            we_count <= 0;
        end
        if (i_reset) begin
            pc <= pc_start; mar <= 8'h00; breg <= 8'h00;
            regs[0] <= 8'h00; regs[1] <= 8'h00;
        end else begin
            if (ram_ae)  mar <= bus;
            if (incr_pc) pc <= pc + 8'd1;
            if (load_pc) pc <= bus;
            if (wr0)     regs[0] <= bus;
            if (wr1)     regs[1] <= bus;
            if (bwr)     breg <= bus;
            if (ram_we) begin
                wmem[mar] <= bus; wvalid[mar] <= 1'b1; we_count <= we_count + 1;
            end
        end
    end

    // Scoreboard and vector table
    typedef struct packed { logic [16:0] ctrl; logic [7:0] ir; } exp_t;
    typedef struct { logic [7:0] ir; int len; logic [4:0][16:0] w; } vec_t;

    exp_t sb[$];
    vec_t vt[18];
    int   checks = 0, errors = 0, cyc = 0;
    logic [7:0] p1 [35];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] i, input int len,
                                input logic [16:0] w2, input logic [16:0] w3, input logic [16:0] w4);
        vec_t v;
        v.ir = i; v.len = len;
        v.w[0] = F0; v.w[1] = F1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        return v;
    endfunction

    task automatic push_word(input logic [16:0] c, input logic [7:0] i);
        sb.push_back({c, i});
    endtask

    task automatic push_instr(input vec_t v, input logic [7:0] prev);
        for (int s = 0; s < v.len; s++) push_word(v.w[s], (s < 2) ? prev : v.ir);
    endtask

    task automatic tick(input logic run, input logic rst);
        @(negedge clk);
        i_run = run; i_reset = rst;
        #1;
        cyc++;
    endtask

    task automatic step_cycle(input logic run, input logic rst);
        exp_t e;
        tick(run, rst);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("ctrl c%0d", cyc), {15'd0, ctrl}, {15'd0, e.ctrl});
            check($sformatf("ir c%0d", cyc), {24'd0, ir}, {24'd0, e.ir});
            check($sformatf("halted c%0d", cyc), {31'd0, halted}, 32'd0);
            check($sformatf("bus_excl c%0d", cyc),
                  {31'd0, $onehot0({alu_oe, bus_en, ram_oe, pc_oe})}, 32'd1);
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) step_cycle(1'b1, 1'b0);
    endtask

    task automatic check_halt(input string tag);
        tick(1'b1, 1'b0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd1);
        check({tag, "_ctrl_idle"}, {15'd0, ctrl}, 32'd0);
        tick(1'b1, 1'b0);
        check({tag, "_ctrl_idle2"}, {15'd0, ctrl}, 32'd0);
    endtask

    initial begin
        logic [7:0] prev;
        int         we_before;

        vt[0]  = mk(8'h10, 4, IMM, RAM_OE | WR0 | INC, 0);
        vt[1]  = mk(8'h11, 4, IMM, RAM_OE | WR1 | INC, 0);
        vt[2]  = mk(8'h21, 4, BUS_EN | BWR | ALU_SEL, ALU_OE | ALU_SEL | WR1, 0);
        vt[3]  = mk(8'h90, 4, IMM, RAM_OE | LDPC, 0);
        vt[4]  = mk(8'h30, 4, BUS_EN | BUS_SEL | BWR | SUB, ALU_OE | BUS_SEL | SUB | WR0, 0);
        vt[5]  = mk(8'h90, 3, INC, 0, 0);
        vt[6]  = mk(8'hA0, 4, IMM, RAM_OE | LDPC, 0);
        vt[7]  = mk(8'h40, 4, BUS_EN | BUS_SEL | BWR | OP0, ALU_OE | BUS_SEL | OP0 | WR0, 0);
        vt[8]  = mk(8'h51, 4, BUS_EN | BWR | ALU_SEL | OP1, ALU_OE | ALU_SEL | OP1 | WR1, 0);
        vt[9]  = mk(8'hA0, 3, INC, 0, 0);
        vt[10] = mk(8'h60, 5, IMM, RAM_OE | RAM_AE | INC, RAM_OE | WR0);
        vt[11] = mk(8'h70, 5, IMM, RAM_OE | RAM_AE | INC, BUS_EN | RAM_WE);
        vt[12] = mk(8'hB0, 4, BUS_EN | BUS_SEL | BWR | OP1 | OP0, ALU_OE | BUS_SEL | OP1 | OP0 | WR0, 0);
        vt[13] = mk(8'hC1, 4, BUS_EN | BWR | ALU_SEL | OP1 | OP0 | SUB,
                    ALU_OE | ALU_SEL | OP1 | OP0 | SUB | WR1, 0);
        vt[14] = mk(8'h00, 3, 0, 0, 0);
        vt[15] = mk(8'hD5, 3, 0, 0, 0);
        vt[16] = mk(8'h80, 4, IMM, RAM_OE | LDPC, 0);
        vt[17] = mk(8'hF0, 3, 0, 0, 0);

        // LDI r0,80; LDI r1,80; ADD r1; JZ 0A (taken); ... ; JMP 22; HLT
        p1 = '{8'h10, 8'h80, 8'h11, 8'h80, 8'h21, 8'h90, 8'h0A, 8'hF0, 8'hF0, 8'hF0,
               8'h30, 8'h90, 8'h20, 8'hA0, 8'h10, 8'hF0, 8'h40, 8'h51, 8'hA0, 8'h30,
               8'h60, 8'h40, 8'h70, 8'h41, 8'hB0, 8'hC1, 8'h00, 8'hD5, 8'h80, 8'h22,
               8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < 35; i++) rom[i] = p1[i];
        rom[8'h40] = 8'hA5;
        rom[8'h50] = 8'h10; rom[8'h51] = 8'h05; rom[8'h52] = 8'h11;
        rom[8'h53] = 8'h03; rom[8'h54] = 8'h30; rom[8'h55] = 8'hF0;
        rom[8'h60] = 8'h60; rom[8'h61] = 8'h40; rom[8'h62] = 8'h70;
        rom[8'h63] = 8'h42; rom[8'h64] = 8'hF0;

        i_reset = 1'b1; i_run = 1'b0; mem_clr = 1'b1; pc_start = 8'h00;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        mem_clr = 1'b0;
        check("reset_ctrl", {15'd0, ctrl}, 32'd0);
        check("reset_ir", {24'd0, ir}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);

        // Program 1: every opcode, both branch outcomes, LD/ST round trip
        prev = 8'h00;
        for (int i = 0; i < 18; i++) begin
            push_instr(vt[i], prev);
            prev = vt[i].ir;
        end
        drain();
        check_halt("p1");
        check("p1_r0", {24'd0, regs[0]}, 32'h4A);
        check("p1_r1", {24'd0, regs[1]}, 32'h00);
        check("p1_st_mem", {23'd0, wvalid[8'h41], wmem[8'h41]}, 32'h1A5);
        check("p1_pc", {24'd0, pc}, 32'h23);

        // Program 2: LDI r0,5; LDI r1,3; SUB r0; HLT -> halted after 15 cycles
        pc_start = 8'h50;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("p2_reset_halted", {31'd0, halted}, 32'd0);
        check("p2_reset_ctrl", {15'd0, ctrl}, 32'd0);
        push_instr(vt[0], 8'h00);
        push_instr(vt[1], 8'h10);
        push_instr(vt[4], 8'h11);
        push_instr(vt[17], 8'h30);
        drain();
        check_halt("p2");
        check("p2_r0", {24'd0, regs[0]}, 32'h02);

        // Program 3: LD frozen at step3 for 3 cycles, then ST interrupted by reset at step3
        pc_start = 8'h60;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("p3_reset_ir", {24'd0, ir}, 32'd0);
        push_word(F0, 8'h00);
        push_word(F1, 8'h00);
        push_word(IMM, 8'h60);
        repeat (3) step_cycle(1'b1, 1'b0);
        push_word(17'd0, 8'h60);
        push_word(17'd0, 8'h60);
        push_word(17'd0, 8'h60);
        repeat (3) step_cycle(1'b0, 1'b0);
        push_word(RAM_OE | RAM_AE | INC, 8'h60);
        push_word(RAM_OE | WR0, 8'h60);
        repeat (2) step_cycle(1'b1, 1'b0);
        check("p3_pc_after_ld", {24'd0, pc}, 32'h62);
        we_before = we_count;
        push_word(F0, 8'h60);
        push_word(F1, 8'h60);
        push_word(IMM, 8'h70);
        repeat (3) step_cycle(1'b1, 1'b0);
        check("p3_ld_r0", {24'd0, regs[0]}, 32'hA5);
        push_word(17'd0, 8'h70);
        step_cycle(1'b1, 1'b1);
        push_word(F0, 8'h00);
        step_cycle(1'b1, 1'b0);
        check("p3_no_write", we_count, we_before);
        check("p3_no_mem", {31'd0, wvalid[8'h42]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
